ofm_pool_writeback: RTL and testbench
=====================================

Name: ofm_pool_writeback

Overview:
- Sits directly downstream of the pooling data-beat generator.
- Consumes the post-pool address/valid/zero/done beat together with the pooled data word, and stores each beat in an internal output buffer.
- Once the layer is done, drains the buffer in address order over a valid/ready stream to the DMA writer.
- Acts as the layer-level boundary between the compute pipeline and external memory.

Parameters:
- ADDR_BIT, 12, width of pool address and log2 of buffer depth.
- DATA_W, 64, pooled data word width (8 lanes x 8 bits).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- shutdown  in  1  synchronous layer abort/clear, same meaning as in the compute pipeline.
- pool_addr  in  ADDR_BIT  buffer write address of current beat.
- pool_valid  in  1  beat valid.
- pool_zero  in  1  beat is padding; store all-zero word.
- pool_done  in  1  one-cycle pulse, last beat of layer (may coincide with final pool_valid).
- pool_data  in  DATA_W  pooled data word, aligned with pool_valid.
- m_tdata  out  DATA_W  drain data.
- m_tvalid  out  1  drain data valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  final drain beat.
- busy  out  1  high in COLLECT or DRAIN.
- drain_done  out  1  one-cycle pulse after final handshake.
- beat_count  out  ADDR_BIT+1  number of beats drained this layer.

Behaviour:
- Reset (rst_n low, async) and shutdown (sync): state=IDLE; m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, drain_done=0, beat_count=0; max-address tracker and drain pointers cleared. Buffer contents are not cleared.
- shutdown in any state, including mid-drain with m_tvalid high, drops m_tvalid next cycle. No further beats are emitted.
- Buffer: 2^ADDR_BIT x DATA_W simple dual-port RAM, 1-cycle registered read.
- Write path, active in IDLE and COLLECT:
  - On pool_valid, write (pool_zero ? 0 : pool_data) at pool_addr in the same cycle.
  - Track len = max(pool_addr)+1 over the layer, ADDR_BIT+1 bits wide.
- State machine:
  - IDLE -> COLLECT on pool_valid. That beat is written.
  - COLLECT -> DRAIN on pool_done. A pool_valid in the same cycle is written first and counted in len.
  - pool_done with no beat written (len=0): no drain beats; drain_done pulses the next cycle; state returns to IDLE.
  - DRAIN: read addresses 0..len-1 in strict order.
  - DRAIN -> IDLE on the handshake (m_tvalid&&m_tready) of beat len-1. drain_done pulses the following cycle. len and the tracker are cleared.
- Drain handshake:
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable.
  - A 2-entry skid (output register + holding register) covers RAM latency, so no beat is lost or duplicated for any m_tready pattern.
  - With m_tready held high, throughput is 1 beat/cycle after a 2-cycle initial latency from entering DRAIN.
- m_tlast=1 only on beat len-1. beat_count increments on each handshake and saturates at len.
- pool_valid or pool_done arriving in DRAIN is ignored: no write, no state change.
- Address wrap: pool_addr=2^ADDR_BIT-1 gives len=2^ADDR_BIT. The width is ADDR_BIT+1 and must not overflow.

Optional Feature:
- Macro: OFM_WB_RELU_EN.
- Defined: each 8-bit lane of the written word is treated as signed. Negative lanes are stored as 0x00, applied after zero forcing, with no added latency.
- Undefined: data is stored unmodified.

Test Plan:
- Write addrs 0..15 with data 0x0101..0x1010, pool_done on addr 15, m_tready=1 -> 16 beats in order, m_tlast on beat 15, drain_done pulses once, beat_count=16.
- Same layer, addr 3 with pool_zero=1 and pool_data=0xFFFF -> beat 3 is 0.
- m_tready toggling 1,0,0,1 repeating during a 16-beat drain -> each beat exactly once, m_tdata stable while stalled.
- shutdown asserted at drain beat 5 with tready=1 -> m_tvalid=0 next cycle, busy=0, no drain_done; a new 4-beat layer afterwards drains correctly.
- pool_done pulse with no prior pool_valid -> zero beats, drain_done one cycle later, state IDLE.
- OFM_WB_RELU_EN defined, data lanes 0x80,0x7F,0xFF,0x01 -> drained lanes 0x00,0x7F,0x00,0x01; undefined -> unchanged.

Source files
------------

// File: rtl/ofm_pool_writeback.sv
// ofm_pool_writeback: collects post-pool beats into an on-chip output buffer,
// then drains the buffer in address order over a valid/ready stream once the
// layer completes. Optional macro OFM_WB_RELU_EN clamps negative 8-bit lanes
// of each written word to zero.
module ofm_pool_writeback #(
  parameter int ADDR_BIT = 12,
  parameter int DATA_W   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shutdown,
  input  logic [ADDR_BIT-1:0] pool_addr,
  input  logic                pool_valid,
  input  logic                pool_zero,
  input  logic                pool_done,
  input  logic [DATA_W-1:0]   pool_data,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                busy,
  output logic                drain_done,
  output logic [ADDR_BIT:0]   beat_count
);

  localparam int DEPTH = 1 << ADDR_BIT;
  localparam logic [ADDR_BIT:0] ONE = {{ADDR_BIT{1'b0}}, 1'b1};
`ifdef OFM_WB_RELU_EN
  localparam int LANES = DATA_W / 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_BIT:0] len, len_nxt, rd_ptr, addr_len;
  logic [1:0]        occ;
  logic              rd_pend, rd_last, hold_valid, hold_last;
  logic              wr_en, issue, pop, done_evt, new_layer;

  assign pop      = m_tvalid && m_tready;
  assign busy     = (state != S_IDLE);
  assign addr_len = {1'b0, pool_addr} + ONE;
  // Beats in flight or parked in the skid: output reg, holding reg, pending read.
  assign occ      = {1'b0, m_tvalid} + {1'b0, hold_valid} + {1'b0, rd_pend};

  // Word to store: padding forced to zero, then optional per-lane ReLU clamp.
  always_comb begin
    wr_word = pool_zero ? '0 : pool_data;
`ifdef OFM_WB_RELU_EN
    for (int i = 0; i < LANES; i++) begin
      if (wr_word[8*i+7]) wr_word[8*i +: 8] = 8'h00;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, write enable, length tracking and read issue decisions.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    wr_en     = 1'b0;
    issue     = 1'b0;
    done_evt  = 1'b0;
    new_layer = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        wr_en = pool_valid;
        if (pool_valid && (addr_len > len)) len_nxt = addr_len;
        if (pool_done) begin
          new_layer = 1'b1;
          if (len_nxt == '0) begin
            state_nxt = S_IDLE;
            done_evt  = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else if (pool_valid) begin
          state_nxt = S_COLLECT;
        end
      end
      S_DRAIN: begin
        // Only issue a read when the skid is guaranteed to have room for it.
        issue = (rd_ptr < len) && ((occ - {1'b0, pop}) < 2'd2);
        if (pop && m_tlast) begin
          state_nxt = S_IDLE;
          done_evt  = 1'b1;
          len_nxt   = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (shutdown) begin
      state_nxt = S_IDLE;
      len_nxt   = '0;
      wr_en     = 1'b0;
      issue     = 1'b0;
      done_evt  = 1'b0;
      new_layer = 1'b0;
    end
  end

  // Output buffer: write port from the pool side, registered read for the drain.
  always_ff @(posedge clk) begin
    if (wr_en) mem[pool_addr] <= wr_word;
    if (issue) rd_data <= mem[rd_ptr[ADDR_BIT-1:0]];
  end

  // Drain pointers, counters and the two-entry output skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      rd_ptr     <= '0;
      rd_pend    <= 1'b0;
      rd_last    <= 1'b0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
      beat_count <= '0;
      drain_done <= 1'b0;
    end else if (shutdown) begin
      len        <= '0;
      rd_ptr     <= '0;
      rd_pend    <= 1'b0;
      rd_last    <= 1'b0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
      beat_count <= '0;
      drain_done <= 1'b0;
    end else begin
      len        <= len_nxt;
      drain_done <= done_evt;
      rd_pend    <= issue;
      rd_last    <= issue && (rd_ptr == (len - ONE));
      if (new_layer) begin
        rd_ptr     <= '0;
        beat_count <= '0;
      end else begin
        if (issue) rd_ptr <= rd_ptr + ONE;
        if (pop && (beat_count < len)) beat_count <= beat_count + ONE;
      end
      if (!m_tvalid || pop) begin
        if (hold_valid) begin
          m_tvalid   <= 1'b1;
          m_tdata    <= hold_data;
          m_tlast    <= hold_last;
          hold_valid <= rd_pend;
          hold_data  <= rd_data;
          hold_last  <= rd_last;
        end else if (rd_pend) begin
          m_tvalid <= 1'b1;
          m_tdata  <= rd_data;
          m_tlast  <= rd_last;
        end else begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
        end
      end else if (rd_pend) begin
        hold_valid <= 1'b1;
        hold_data  <= rd_data;
        hold_last  <= rd_last;
      end
    end
  end

endmodule

// File: tb/tb_ofm_pool_writeback.sv
// tb_ofm_pool_writeback: randomized, self-checking bench for ofm_pool_writeback
// with a behavioural buffer model; honours OFM_WB_RELU_EN when defined.
module tb_ofm_pool_writeback;

  localparam int AB    = 12;
  localparam int DW    = 64;
  localparam int DEPTH = 4096;

  logic          clk, rst_n, shutdown;
  logic [AB-1:0] pool_addr;
  logic          pool_valid, pool_zero, pool_done;
  logic [DW-1:0] pool_data, m_tdata;
  logic          m_tvalid, m_tready, m_tlast, busy, drain_done;
  logic [AB:0]   beat_count;

  int n_checks, n_errors, done_pulses, stall_viol, cycle;
  bit prev_stall;
  logic [DW-1:0] prev_data;
  logic prev_last;

  logic [DW:0]   got_q[$];
  int            got_cyc[$];
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            lay_addr[$];
  logic [DW-1:0] lay_data[$];
  bit            lay_zero[$];

  ofm_pool_writeback #(.ADDR_BIT(AB), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .shutdown(shutdown),
    .pool_addr(pool_addr), .pool_valid(pool_valid), .pool_zero(pool_zero),
    .pool_done(pool_done), .pool_data(pool_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .drain_done(drain_done), .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Observe the stream away from the active edge: handshakes, done pulses, stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        got_cyc.push_back(cycle);
      end
      if (drain_done) done_pulses++;
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last)) stall_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // What the buffer should hold for a beat.
  function automatic logic [DW-1:0] model_word(input bit z, input logic [DW-1:0] d);
    logic [DW-1:0] w;
    w = z ? '0 : d;
`ifdef OFM_WB_RELU_EN
    for (int l = 0; l < 8; l++) if ($signed(w[8*l +: 8]) < 0) w[8*l +: 8] = 8'h00;
`endif
    return w;
  endfunction

  // Drive the queued layer, update the model and build the expected drain list.
  task automatic send_layer(input bit done_sep);
    int mx;
    mx = -1;
    for (int k = 0; k < lay_addr.size(); k++) begin
      @(posedge clk); #1;
      pool_valid = 1'b1;
      pool_addr  = AB'(lay_addr[k]);
      pool_data  = lay_data[k];
      pool_zero  = lay_zero[k];
      pool_done  = (k == lay_addr.size() - 1) && !done_sep;
      model_mem[lay_addr[k]] = model_word(lay_zero[k], lay_data[k]);
      if (lay_addr[k] > mx) mx = lay_addr[k];
    end
    @(posedge clk); #1;
    pool_valid = 1'b0;
    pool_done  = 1'b0;
    pool_zero  = 1'b0;
    if (done_sep) begin
      pool_done = 1'b1;
      @(posedge clk); #1;
      pool_done = 1'b0;
    end
    exp_q.delete();
    for (int i = 0; i <= mx; i++) exp_q.push_back({(i == mx), model_mem[i]});
  endtask

  // Wait for a drain_done pulse, driving m_tready per mode (0 high, 1 pattern 1001, 2 random).
  task automatic wait_drain(input int d0, input int budget, input int mode, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ((i % 4) == 0) || ((i % 4) == 3);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (done_pulses != d0) begin
        ok = 1'b1;
        break;
      end
    end
    m_tready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; shutdown = 1'b0; pool_valid = 1'b0; pool_zero = 1'b0; pool_done = 1'b0;
    pool_addr = '0; pool_data = '0; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0)   begin n_errors++; $display("[TB] FAIL reset_tvalid got %b want 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0)    begin n_errors++; $display("[TB] FAIL reset_tlast got %b want 0", m_tlast); end
    n_checks++; if (m_tdata !== '0)      begin n_errors++; $display("[TB] FAIL reset_tdata got %h want 0", m_tdata); end
    n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (drain_done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_drain_done got %b want 0", drain_done); end
    n_checks++; if (beat_count !== '0)   begin n_errors++; $display("[TB] FAIL reset_beat_count got %0d want 0", beat_count); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_drain();
    int d0; bit ok;
    lay_addr.delete(); lay_data.delete(); lay_zero.delete();
    for (int i = 0; i < 16; i++) begin
      lay_addr.push_back(i);
      lay_data.push_back((i == 3) ? 64'hFFFF : 64'(i + 1) * 64'h0101);
      lay_zero.push_back(i == 3);
    end
    got_q.delete(); got_cyc.delete(); d0 = done_pulses;
    send_layer(1'b0);
    wait_drain(d0, 200, 0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL basic_timeout got no drain_done want pulse"); end
    n_checks++; if (got_q.size() != 16) begin n_errors++; $display("[TB] FAIL basic_count got %0d want 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("[TB] FAIL basic_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 16) begin
      n_checks++; if (got_q[3][DW-1:0] !== 64'h0) begin n_errors++; $display("[TB] FAIL basic_zero_beat got %h want 0", got_q[3][DW-1:0]); end
      n_checks++; if (got_q[0][DW-1:0] !== 64'h0101) begin n_errors++; $display("[TB] FAIL basic_first_beat got %h want 0101", got_q[0][DW-1:0]); end
      n_checks++; if (got_cyc[15] - got_cyc[0] != 15) begin n_errors++; $display("[TB] FAIL basic_throughput got %0d want 15 cycles", got_cyc[15] - got_cyc[0]); end
    end
    n_checks++; if (beat_count !== 13'd16) begin n_errors++; $display("[TB] FAIL basic_beat_count got %0d want 16", beat_count); end
    repeat (3) @(negedge clk);
    n_checks++; if (done_pulses != d0 + 1) begin n_errors++; $display("[TB] FAIL basic_done_pulses got %0d want 1", done_pulses - d0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL basic_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int d0, v0; bit ok;
    lay_addr.delete(); lay_data.delete(); lay_zero.delete();
    for (int i = 0; i < 16; i++) begin
      lay_addr.push_back(i); lay_data.push_back({$urandom, $urandom}); lay_zero.push_back(1'b0);
    end
    got_q.delete(); got_cyc.delete(); d0 = done_pulses; v0 = stall_viol;
    send_layer(1'b1);
    wait_drain(d0, 300, 1, ok);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL bp_timeout got no drain_done want pulse"); end
    n_checks++; if (got_q.size() != 16) begin n_errors++; $display("[TB] FAIL bp_count got %0d want 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("[TB] FAIL bp_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (stall_viol != v0) begin n_errors++; $display("[TB] FAIL bp_stall_stable got %0d changes want 0", stall_viol - v0); end
    n_checks++; if (beat_count !== 13'd16) begin n_errors++; $display("[TB] FAIL bp_beat_count got %0d want 16", beat_count); end
  endtask

  task automatic test_random_layers();
    int d0, v0, len; bit ok;
    int perm[$];
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 40);
      perm.delete();
      for (int i = 0; i < len; i++) perm.push_back(i);
      for (int i = len - 1; i > 0; i--) begin
        int j; int t;
        j = $urandom_range(0, i); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      perm.push_back($urandom_range(0, len - 1));
      lay_addr.delete(); lay_data.delete(); lay_zero.delete();
      foreach (perm[i]) begin
        lay_addr.push_back(perm[i]); lay_data.push_back({$urandom, $urandom});
        lay_zero.push_back($urandom_range(0, 4) == 0);
      end
      got_q.delete(); got_cyc.delete(); d0 = done_pulses; v0 = stall_viol;
      send_layer(1'($urandom_range(0, 1)));
      wait_drain(d0, len * 8 + 40, 2, ok);
      n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL rand%0d_timeout got no drain_done want pulse", r); end
      n_checks++; if (got_q.size() != len) begin n_errors++; $display("[TB] FAIL rand%0d_count got %0d want %0d", r, got_q.size(), len); end
      for (int i = 0; i < len && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_errors++; $display("[TB] FAIL rand%0d_beat%0d got %h want %h", r, i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (stall_viol != v0) begin n_errors++; $display("[TB] FAIL rand%0d_stall_stable got %0d changes want 0", r, stall_viol - v0); end
      n_checks++; if (beat_count !== 13'(len)) begin n_errors++; $display("[TB] FAIL rand%0d_beat_count got %0d want %0d", r, beat_count, len); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_shutdown();
    int d0; bit ok, seen;
    lay_addr.delete(); lay_data.delete(); lay_zero.delete();
    for (int i = 0; i < 16; i++) begin
      lay_addr.push_back(i); lay_data.push_back({$urandom, $urandom}); lay_zero.push_back(1'b0);
    end
    got_q.delete(); got_cyc.delete(); d0 = done_pulses; seen = 1'b0;
    send_layer(1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (got_q.size() >= 5) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_errors++; $display("[TB] FAIL sd_reach_beat5 got %0d beats want 5", got_q.size()); end
    shutdown = 1'b1;
    @(posedge clk); #1;
    shutdown = 1'b0;
    @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0) begin n_errors++; $display("[TB] FAIL sd_tvalid got %b want 0", m_tvalid); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL sd_busy got %b want 0", busy); end
    repeat (10) @(negedge clk);
    n_checks++; if (done_pulses != d0) begin n_errors++; $display("[TB] FAIL sd_no_done got %0d pulses want 0", done_pulses - d0); end
    n_checks++; if (got_q.size() != 6) begin n_errors++; $display("[TB] FAIL sd_beats got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][DW-1:0] !== exp_q[i][DW-1:0]) begin n_errors++; $display("[TB] FAIL sd_beat%0d got %h want %h", i, got_q[i][DW-1:0], exp_q[i][DW-1:0]); end
    end
    lay_addr.delete(); lay_data.delete(); lay_zero.delete();
    for (int i = 0; i < 4; i++) begin
      lay_addr.push_back(3 - i); lay_data.push_back({$urandom, $urandom}); lay_zero.push_back(1'b0);
    end
    got_q.delete(); got_cyc.delete(); d0 = done_pulses;
    send_layer(1'b0);
    wait_drain(d0, 100, 0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL sd_next_timeout got no drain_done want pulse"); end
    n_checks++; if (got_q.size() != 4) begin n_errors++; $display("[TB] FAIL sd_next_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("[TB] FAIL sd_next_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (beat_count !== 13'd4) begin n_errors++; $display("[TB] FAIL sd_next_beat_count got %0d want 4", beat_count); end
  endtask

  task automatic test_zero_layer();
    int d0;
    got_q.delete(); d0 = done_pulses;
    @(posedge clk); #1;
    pool_done = 1'b1;
    @(posedge clk); #1;
    pool_done = 1'b0;
    @(negedge clk);
    n_checks++; if (drain_done !== 1'b1) begin n_errors++; $display("[TB] FAIL zero_done_pulse got %b want 1", drain_done); end
    @(negedge clk);
    n_checks++; if (drain_done !== 1'b0) begin n_errors++; $display("[TB] FAIL zero_done_single got %b want 0", drain_done); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL zero_busy got %b want 0", busy); end
    repeat (4) @(negedge clk);
    n_checks++; if (got_q.size() != 0) begin n_errors++; $display("[TB] FAIL zero_beats got %0d want 0", got_q.size()); end
    n_checks++; if (done_pulses != d0 + 1) begin n_errors++; $display("[TB] FAIL zero_done_count got %0d want 1", done_pulses - d0); end
    n_checks++; if (beat_count !== '0) begin n_errors++; $display("[TB] FAIL zero_beat_count got %0d want 0", beat_count); end
  endtask

  task automatic test_relu();
    int d0; bit ok;
    logic [31:0] want_lo;
`ifdef OFM_WB_RELU_EN
    want_lo = 32'h01007F00;
`else
    want_lo = 32'h01FF7F80;
`endif
    lay_addr.delete(); lay_data.delete(); lay_zero.delete();
    lay_addr.push_back(0); lay_data.push_back({$urandom, 32'h01FF7F80}); lay_zero.push_back(1'b0);
    got_q.delete(); d0 = done_pulses;
    send_layer(1'b0);
    wait_drain(d0, 50, 0, ok);
    n_checks++; if (got_q.size() != 1) begin n_errors++; $display("[TB] FAIL relu_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0][31:0] !== want_lo) begin n_errors++; $display("[TB] FAIL relu_lanes got %h want %h", got_q[0][31:0], want_lo); end
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("[TB] FAIL relu_word got %h want %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_wrap();
    int d0, nlast; bit ok;
    lay_addr.delete(); lay_data.delete(); lay_zero.delete();
    lay_addr.push_back(DEPTH - 1); lay_data.push_back({$urandom, $urandom}); lay_zero.push_back(1'b0);
    got_q.delete(); d0 = done_pulses;
    send_layer(1'b0);
    wait_drain(d0, DEPTH + 200, 0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL wrap_timeout got no drain_done want pulse"); end
    n_checks++; if (got_q.size() != DEPTH) begin n_errors++; $display("[TB] FAIL wrap_count got %0d want %0d", got_q.size(), DEPTH); end
    nlast = 0;
    foreach (got_q[i]) if (got_q[i][DW]) nlast++;
    n_checks++; if (nlast != 1) begin n_errors++; $display("[TB] FAIL wrap_tlast_count got %0d want 1", nlast); end
    if (got_q.size() == DEPTH) begin
      n_checks++; if (got_q[DEPTH-1] !== exp_q[DEPTH-1]) begin n_errors++; $display("[TB] FAIL wrap_last_beat got %h want %h", got_q[DEPTH-1], exp_q[DEPTH-1]); end
    end
    n_checks++; if (beat_count !== 13'd4096) begin n_errors++; $display("[TB] FAIL wrap_beat_count got %0d want 4096", beat_count); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; done_pulses = 0; stall_viol = 0; cycle = 0;
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_random_layers();
    test_shutdown();
    test_zero_layer();
    test_relu();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound so the bench can never hang.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
